// File: rtl/i2c_pkg.sv
// Shared command encodings and byte-controller state type for the I2C master.
// Command values are common to the byte and bit controllers.
package i2c_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;
    localparam int CMD_W  = 4;

    localparam logic [CMD_W-1:0] CMD_NOP   = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_START = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_STOP  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_WRITE = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_READ  = 4'b1000;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_START = 6'b000010,
        ST_READ  = 6'b000100,
        ST_WRITE = 6'b001000,
        ST_ACK   = 6'b010000,
        ST_STOP  = 6'b100000
    } byte_state_e;

    // Bit-controller command that moves one data bit in the requested direction.
    function automatic logic [CMD_W-1:0] data_cmd(input logic is_read);
        return is_read ? CMD_READ : CMD_WRITE;
    endfunction

endpackage

// File: rtl/i2c_master_byte_ctrl_if.sv
// Host request/response and bit-controller command bundle for the byte controller.
// master = the byte controller itself; slave = host plus bit controller.
interface i2c_master_byte_ctrl_if;
    import i2c_pkg::*;

    logic              start;
    logic              stop;
    logic              read;
    logic              write;
    logic              ack_in;
    logic [DATA_W-1:0] din;
    logic              cmd_ack;
    logic              ack_out;
    logic [DATA_W-1:0] dout;
    logic              i2c_al;

    logic [CMD_W-1:0]  core_cmd;
    logic              core_txd;
    logic              core_ack;
    logic              core_rxd;
    logic              bit_al;

    modport master (
        input  start, stop, read, write, ack_in, din,
        output cmd_ack, ack_out, dout, i2c_al,
        output core_cmd, core_txd,
        input  core_ack, core_rxd, bit_al
    );

    modport slave (
        output start, stop, read, write, ack_in, din,
        input  cmd_ack, ack_out, dout, i2c_al,
        input  core_cmd, core_txd,
        output core_ack, core_rxd, bit_al
    );

endinterface

// File: rtl/i2c_master_byte_ctrl.sv
// I2C byte sequencer: expands one host request into START / 8 data bits / ACK / STOP
// bit-controller commands, shifting tx and rx data; arbitration loss aborts to idle.
module i2c_master_byte_ctrl
    import i2c_pkg::*;
(
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   rst,
    i2c_master_byte_ctrl_if.master bus
);

    byte_state_e       state_q, state_d;
    logic [CMD_W-1:0]  core_cmd_q, core_cmd_d;
    logic              core_txd_q, core_txd_d;
    logic              cmd_ack_q, cmd_ack_d;
    logic              ack_out_q, ack_out_d;
    logic              i2c_al_q;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic go;
    logic last_bit;

    // cmd_ack masks the request so a request still held in the ack cycle is not re-run.
    assign go       = (bus.start | bus.stop | bus.read | bus.write) & ~cmd_ack_q;
    assign last_bit = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!nReset || rst) begin
            state_q    <= ST_IDLE;
            core_cmd_q <= CMD_NOP;
            core_txd_q <= 1'b0;
            cmd_ack_q  <= 1'b0;
            ack_out_q  <= 1'b0;
            i2c_al_q   <= 1'b0;
            sr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            core_cmd_q <= core_cmd_d;
            core_txd_q <= core_txd_d;
            cmd_ack_q  <= cmd_ack_d;
            ack_out_q  <= ack_out_d;
            i2c_al_q   <= bus.bit_al;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        core_cmd_d = core_cmd_q;
        core_txd_d = core_txd_q;
        cmd_ack_d  = 1'b0;
        ack_out_d  = ack_out_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;

        if (bus.bit_al) begin
            // Lost the bus: drop everything, keep data and ack_out for inspection.
            state_d    = ST_IDLE;
            core_cmd_d = CMD_NOP;
            core_txd_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        sr_d       = bus.din;
                        cnt_d      = CNT_W'(DATA_W - 1);
                        core_txd_d = bus.din[DATA_W-1];
                        if (bus.start) begin
                            state_d    = ST_START;
                            core_cmd_d = CMD_START;
                        end else if (bus.read) begin
                            state_d    = ST_READ;
                            core_cmd_d = CMD_READ;
                        end else if (bus.write) begin
                            state_d    = ST_WRITE;
                            core_cmd_d = CMD_WRITE;
                        end else begin
                            state_d    = ST_STOP;
                            core_cmd_d = CMD_STOP;
                        end
                    end
                end

                ST_START: begin
                    if (bus.core_ack) begin
                        state_d    = bus.read ? ST_READ : ST_WRITE;
                        core_cmd_d = data_cmd(bus.read);
                        core_txd_d = sr_q[DATA_W-1];
                    end
                end

                ST_WRITE, ST_READ: begin
                    if (bus.core_ack) begin
                        sr_d = {sr_q[DATA_W-2:0], bus.core_rxd};
                        if (last_bit) begin
                            // Ninth clock: the ACK bit runs in the opposite direction.
                            state_d = ST_ACK;
                            if (state_q == ST_WRITE) begin
                                core_cmd_d = CMD_READ;
                                core_txd_d = 1'b1;
                            end else begin
                                core_cmd_d = CMD_WRITE;
                                core_txd_d = bus.ack_in;
                            end
                        end else begin
                            cnt_d      = cnt_q - 1'b1;
                            core_txd_d = sr_q[DATA_W-2];
                        end
                    end
                end

                ST_ACK: begin
                    if (bus.core_ack) begin
                        ack_out_d = bus.core_rxd;
                        if (bus.stop) begin
                            state_d    = ST_STOP;
                            core_cmd_d = CMD_STOP;
                        end else begin
                            state_d    = ST_IDLE;
                            core_cmd_d = CMD_NOP;
                            cmd_ack_d  = 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (bus.core_ack) begin
                        state_d    = ST_IDLE;
                        core_cmd_d = CMD_NOP;
                        cmd_ack_d  = 1'b1;
                    end
                end

                default: begin
                    state_d    = ST_IDLE;
                    core_cmd_d = CMD_NOP;
                end
            endcase
        end
    end

    assign bus.cmd_ack  = cmd_ack_q;
    assign bus.ack_out  = ack_out_q;
    assign bus.dout     = sr_q;
    assign bus.i2c_al   = i2c_al_q;
    assign bus.core_cmd = core_cmd_q;
    assign bus.core_txd = core_txd_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: plays host and bit controller, predicting each request's
// command list, tx bits, received byte and ack from the request fields.
module tb_i2c_master_byte_ctrl;
    import i2c_pkg::*;

    localparam int K_CTRL = 0;
    localparam int K_DATA = 1;
    localparam int K_ACK  = 2;

    typedef struct {
        logic [3:0] cmd;
        logic       txd;
        int         kind;
    } exp_t;

    logic clk = 1'b0;
    logic nReset;
    logic rst;

    always #5 clk = ~clk;

    i2c_master_byte_ctrl_if bus();

    i2c_master_byte_ctrl dut (
        .clk    (clk),
        .nReset (nReset),
        .rst    (rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drop_req();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rst core_cmd"}, 32'(bus.core_cmd), 32'(CMD_NOP));
        chk({tag, " rst core_txd"}, 32'(bus.core_txd), 0);
        chk({tag, " rst cmd_ack"},  32'(bus.cmd_ack), 0);
        chk({tag, " rst ack_out"},  32'(bus.ack_out), 0);
        chk({tag, " rst i2c_al"},   32'(bus.i2c_al), 0);
        chk({tag, " rst dout"},     32'(bus.dout), 0);
    endtask

    // Called at a negedge. abort_kind: 0 none, 1 bit_al with core_ack, 2 nReset, 3 rst,
    // applied on data bit number abort_at instead of its normal acknowledge.
    task automatic run_txn(input string tag, input logic s, input logic p, input logic r,
                           input logic w, input logic ai, input logic [7:0] d,
                           input logic [7:0] rx, input logic ab, input int abort_kind,
                           input int abort_at, input bit hold_extra, output logic [7:0] seen);
        exp_t q[$];
        exp_t e;
        logic [7:0] msr;
        int idx, bitn, wcnt, pending, cyc;
        bit done;

        seen = '0; msr = d; idx = 0; bitn = 0; wcnt = 0; pending = 0; cyc = 0; done = 1'b0;
        if (r || w) begin
            if (s) begin
                e.cmd = CMD_START; e.txd = 1'b0; e.kind = K_CTRL; q.push_back(e);
            end
            for (int i = 0; i < 8; i++) begin
                e.cmd = r ? CMD_READ : CMD_WRITE; e.txd = d[3'(7 - i)]; e.kind = K_DATA;
                q.push_back(e);
            end
            e.cmd = r ? CMD_WRITE : CMD_READ; e.txd = r ? ai : 1'b1; e.kind = K_ACK;
            q.push_back(e);
        end
        if (p) begin
            e.cmd = CMD_STOP; e.txd = 1'b0; e.kind = K_CTRL; q.push_back(e);
        end

        bus.start = s; bus.stop = p; bus.read = r; bus.write = w;
        bus.ack_in = ai; bus.din = d;

        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.core_ack = 1'b0;
            if (pending == 2) begin
                chk({tag, " al core_cmd"}, 32'(bus.core_cmd), 32'(CMD_NOP));
                chk({tag, " al i2c_al"},   32'(bus.i2c_al), 1);
                chk({tag, " al cmd_ack"},  32'(bus.cmd_ack), 0);
                chk({tag, " al core_txd"}, 32'(bus.core_txd), 0);
                chk({tag, " al dout held"}, 32'(bus.dout), 32'(msr));
                bus.bit_al = 1'b0;
                drop_req();
                @(negedge clk);
                chk({tag, " al clear i2c_al"}, 32'(bus.i2c_al), 0);
                chk({tag, " al idle cmd"},     32'(bus.core_cmd), 32'(CMD_NOP));
                chk({tag, " al no cmd_ack"},   32'(bus.cmd_ack), 0);
                done = 1'b1;
            end else if (pending == 3) begin
                chk_reset_vals(tag);
                nReset = 1'b1;
                rst    = 1'b0;
                drop_req();
                @(negedge clk);
                chk({tag, " post-rst cmd"},     32'(bus.core_cmd), 32'(CMD_NOP));
                chk({tag, " post-rst cmd_ack"}, 32'(bus.cmd_ack), 0);
                done = 1'b1;
            end else if (pending == 1 && idx >= q.size()) begin
                chk({tag, " done core_cmd"}, 32'(bus.core_cmd), 32'(CMD_NOP));
                chk({tag, " done cmd_ack"},  32'(bus.cmd_ack), 1);
                chk({tag, " done dout"},     32'(bus.dout), 32'(msr));
                if (r || w) chk({tag, " done ack_out"}, 32'(bus.ack_out), 32'(ab));
                if (!hold_extra) drop_req();
                @(negedge clk);
                chk({tag, " after cmd"},     32'(bus.core_cmd), 32'(CMD_NOP));
                chk({tag, " after cmd_ack"}, 32'(bus.cmd_ack), 0);
                drop_req();
                repeat (2) begin
                    @(negedge clk);
                    chk({tag, " quiet cmd"},     32'(bus.core_cmd), 32'(CMD_NOP));
                    chk({tag, " quiet cmd_ack"}, 32'(bus.cmd_ack), 0);
                end
                done = 1'b1;
            end else begin
                pending = 0;
                if (wcnt == 0) begin
                    // First cycle of a command: it must follow the previous ack with no gap.
                    chk({tag, " cmd"},     32'(bus.core_cmd), 32'(q[idx].cmd));
                    chk({tag, " cmd_ack"}, 32'(bus.cmd_ack), 0);
                    chk({tag, " i2c_al"},  32'(bus.i2c_al), 0);
                    if (q[idx].kind != K_CTRL)
                        chk({tag, " core_txd"}, 32'(bus.core_txd), 32'(q[idx].txd));
                    if (q[idx].kind == K_DATA) seen = {seen[6:0], bus.core_txd};
                    wcnt = 1;
                end else begin
                    chk({tag, " cmd held"}, 32'(bus.core_cmd), 32'(q[idx].cmd));
                    if (q[idx].kind == K_DATA && abort_kind == 1 && bitn == abort_at) begin
                        bus.core_ack = 1'b1;
                        bus.core_rxd = rx[3'(7 - bitn)];
                        bus.bit_al   = 1'b1;
                        pending = 2;
                    end else if (q[idx].kind == K_DATA && abort_kind >= 2 && bitn == abort_at) begin
                        if (abort_kind == 2) nReset = 1'b0;
                        else                 rst    = 1'b1;
                        pending = 3;
                    end else begin
                        bus.core_ack = 1'b1;
                        if (q[idx].kind == K_DATA) begin
                            bus.core_rxd = rx[3'(7 - bitn)];
                            msr  = {msr[6:0], rx[3'(7 - bitn)]};
                            bitn++;
                        end else begin
                            bus.core_rxd = (q[idx].kind == K_ACK) ? ab : 1'b0;
                        end
                        idx++;
                        pending = 1;
                        wcnt    = 0;
                    end
                end
            end
        end
        if (!done) begin
            chk({tag, " timeout"}, 0, 1);
            drop_req();
            bus.core_ack = 1'b0;
            bus.bit_al   = 1'b0;
            nReset = 1'b1;
            rst    = 1'b0;
        end
    endtask

    logic [7:0] seen;

    initial begin
        nReset = 1'b0;
        rst    = 1'b0;
        drop_req();
        bus.ack_in   = 1'b0;
        bus.din      = 8'h00;
        bus.core_ack = 1'b0;
        bus.core_rxd = 1'b0;
        bus.bit_al   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("init");
        nReset = 1'b1;
        @(negedge clk);

        // START + write 0xA5 + STOP, slave ACKs.
        run_txn("wr_a5", 1, 1, 0, 1, 0, 8'hA5, 8'hA5, 1'b0, 0, 0, 0, seen);
        chk("wr_a5 txd bits", 32'(seen), 32'h0000_00A5);
        chk("wr_a5 ack_out", 32'(bus.ack_out), 0);

        // Read 0x3C, NACK it, no START/STOP.
        run_txn("rd_3c", 0, 0, 1, 0, 1, 8'hFF, 8'h3C, 1'b1, 0, 0, 0, seen);
        chk("rd_3c dout", 32'(bus.dout), 32'h0000_003C);
        chk("rd_3c ack_out", 32'(bus.ack_out), 1);

        // STOP only.
        run_txn("stop", 0, 1, 0, 0, 0, 8'h00, 8'h00, 1'b0, 0, 0, 0, seen);

        // Arbitration lost on the 4th write bit, coincident with core_ack.
        run_txn("al", 0, 0, 0, 1, 0, 8'h96, 8'h96, 1'b0, 1, 3, 0, seen);
        chk("al dout literal", 32'(bus.dout), 32'h0000_00B4);
        run_txn("post_al", 1, 0, 0, 1, 0, 8'h5A, 8'h5A, 1'b1, 0, 0, 0, seen);

        // nReset mid-read, then a clean write of 0x01.
        run_txn("nrst_rd", 0, 0, 1, 0, 0, 8'hFF, 8'hC7, 1'b0, 2, 4, 0, seen);
        run_txn("wr_01a", 1, 1, 0, 1, 0, 8'h01, 8'h01, 1'b0, 0, 0, 0, seen);
        chk("wr_01a txd bits", 32'(seen), 32'h0000_0001);

        // Soft rst mid-read, then a clean write of 0x01.
        run_txn("rst_rd", 0, 0, 1, 0, 0, 8'hFF, 8'h69, 1'b0, 3, 2, 0, seen);
        run_txn("wr_01b", 0, 0, 0, 1, 0, 8'h01, 8'h01, 1'b0, 0, 0, 0, seen);

        // Request held one cycle past cmd_ack must not rerun.
        run_txn("hold", 0, 0, 0, 1, 0, 8'hC3, 8'hC3, 1'b0, 0, 0, 1, seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
